// File: rtl/wb_common_pkg.sv
// Wishbone constants shared by the SDRAM initiators.
// Cycle-type codes, burst type and the pattern LFSR step.
package wb_common_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;

  function automatic logic [31:0] lfsr_next(input logic [31:0] q);
    return {1'b0, q[31:1]} ^ (q[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/wb_sdram_lfsr.sv
// 32-bit right-shifting Galois LFSR used as the test pattern.
// Load wins over step; one instance serves both phases.
module wb_sdram_lfsr
  import wb_common_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] seed,
  output logic [31:0] q
);

  // pattern register: reload on phase start, advance per acked beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= '0;
    else if (load) q <= seed;
    else if (step) q <= lfsr_next(q);
  end

endmodule

// File: rtl/wb_sdram_selftest.sv
// Wishbone SDRAM self-test initiator: burst write a pattern,
// read it back, count mismatches and watch for bus hangs.
module wb_sdram_selftest
  import wb_common_pkg::*;
#(
  parameter logic [31:0] ADDR_LOW  = 32'h0,
  parameter int          WORDS     = 4096,
  parameter int          BURST_LEN = 8,
  parameter logic [31:0] SEED      = 32'hACE1_2468,
  parameter int          TIMEOUT   = 1024
)(
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] err_count,
  output logic [31:0] err_adr,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [2:0]  wb_cti_o,
  output logic [1:0]  wb_bte_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_BURST = 3'd1;
  localparam logic [2:0] S_WR_GAP   = 3'd2;
  localparam logic [2:0] S_RD_BURST = 3'd3;
  localparam logic [2:0] S_RD_GAP   = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam int BW =
    (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);
  localparam logic [31:0] WORDS_W  = 32'(WORDS);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);
  localparam logic [2:0] CTI_FIRST =
    (BURST_LEN == 1) ? CTI_CLASSIC : CTI_INC;

  logic [2:0]    state;
  logic [BW-1:0] beat;
  logic [31:0]   words;
  logic [31:0]   wd;
  logic          cyc;
  logic [31:0]   lfsr_q;
  logic          go;
  logic          ack;
  logic          in_burst;
  logic          last_beat;
  logic          bus_tmo;
  logic          rd_miss;
  logic          lfsr_load;

  // cyc and stb move together; an ack outside a cycle is ignored
  assign ack       = wb_ack_i & cyc;
  assign go        = (state == S_IDLE) & start;
  assign in_burst  = (state == S_WR_BURST) |
                     (state == S_RD_BURST);
  assign last_beat = (beat == BEAT_LAST);
  assign bus_tmo   = in_burst & ~ack & (wd == TMO_LAST);
  assign rd_miss   = ack & (state == S_RD_BURST) &
                     (wb_dat_i != lfsr_q);
  assign lfsr_load = go |
                     ((state == S_WR_GAP) & (words == WORDS_W));

  assign wb_cyc_o = cyc;
  assign wb_stb_o = cyc;
  assign wb_dat_o = lfsr_q;
  assign wb_sel_o = 4'hF;
  assign wb_bte_o = BTE_LINEAR;

  wb_sdram_lfsr u_lfsr (
    .clk  (wb_clk),
    .rst  (wb_rst),
    .load (lfsr_load),
    .step (ack),
    .seed (SEED),
    .q    (lfsr_q)
  );

  // sequencer: bursts, gaps, address/cti per beat and watchdog
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state    <= S_IDLE;
      beat     <= '0;
      words    <= '0;
      wd       <= '0;
      cyc      <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= '0;
      wb_cti_o <= CTI_CLASSIC;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_WR_BURST;
            beat     <= '0;
            words    <= '0;
            wd       <= '0;
            cyc      <= 1'b1;
            wb_we_o  <= 1'b1;
            wb_adr_o <= ADDR_LOW;
            wb_cti_o <= CTI_FIRST;
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            timeout  <= 1'b0;
          end
        end
        S_WR_BURST, S_RD_BURST: begin
          if (ack) begin
            wb_adr_o <= wb_adr_o + 32'd4;
            words    <= words + 32'd1;
            wd       <= '0;
            if (last_beat) begin
              cyc   <= 1'b0;
              state <= (state == S_WR_BURST) ?
                       S_WR_GAP : S_RD_GAP;
            end else begin
              beat     <= beat + 1'b1;
              wb_cti_o <= (beat + 1'b1 == BEAT_LAST) ?
                          CTI_EOB : CTI_INC;
            end
          end else if (bus_tmo) begin
            cyc     <= 1'b0;
            wb_we_o <= 1'b0;
            timeout <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b0;
            state   <= S_DONE;
          end else begin
            wd <= wd + 32'd1;
          end
        end
        S_WR_GAP: begin
          beat     <= '0;
          wd       <= '0;
          cyc      <= 1'b1;
          wb_cti_o <= CTI_FIRST;
          if (words == WORDS_W) begin
            state    <= S_RD_BURST;
            words    <= '0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= ADDR_LOW;
          end else begin
            state <= S_WR_BURST;
          end
        end
        S_RD_GAP: begin
          if (words == WORDS_W) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == 16'h0);
          end else begin
            state    <= S_RD_BURST;
            beat     <= '0;
            wd       <= '0;
            cyc      <= 1'b1;
            wb_cti_o <= CTI_FIRST;
          end
        end
        S_DONE: begin
          if (start) begin
            state <= S_IDLE;
            done  <= 1'b0;
            pass  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          cyc   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // read checker: saturating miss count, first failing address
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      err_count <= '0;
      err_adr   <= '0;
    end else if (go) begin
      err_count <= '0;
      err_adr   <= '0;
    end else if (rd_miss) begin
      if (err_count == 16'h0)
        err_adr <= wb_adr_o;
      if (err_count != 16'hFFFF)
        err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_wb_sdram_selftest.sv
// Bench: two self-test instances (8-beat and classic) against
// random-wait memory slaves and a word-level bus model.
module tb_wb_sdram_selftest;

  localparam logic [31:0] SEED = 32'hACE1_2468;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  start, cyc, stb, we, ack;
  logic [1:0]  busy, done, pass, tmo;
  logic [31:0] adr [2];
  logic [31:0] dato [2];
  logic [31:0] dati [2];
  logic [31:0] errad [2];
  logic [2:0]  cti [2];
  logic [1:0]  bte [2];
  logic [3:0]  sel [2];
  logic [15:0] errc [2];

  logic [1:0]  go, fault, noack;
  int unsigned maxw [2];
  logic [31:0] pat [64];

  int checks = 0;
  int errors = 0;

  function automatic int bl_of(input int i);
    return (i == 0) ? 8 : 1;
  endfunction
  function automatic int words_of(input int i);
    return (i == 0) ? 64 : 16;
  endfunction
  function automatic logic [31:0] base_of(input int i);
    return (i == 0) ? 32'h0 : 32'h100;
  endfunction

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, a, e, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int BL = (g == 0) ? 8 : 1;
    localparam int WD = (g == 0) ? 64 : 16;
    localparam logic [31:0] BASE = (g == 0) ? 32'h0 : 32'h100;

    logic [31:0] mem [64];
    int stall = 0;
    int target = 0;
    logic [5:0] idx;
    logic [31:0] mask;

    assign idx  = 6'((adr[g] - BASE) >> 2);
    assign mask = (fault[g] && adr[g] >= 32'h40) ?
                  ~32'h20 : 32'hFFFF_FFFF;
    assign dati[g] = mem[idx] & mask;
    assign ack[g]  = cyc[g] & stb[g] & ~noack[g] &
                     (stall >= target);

    always @(posedge clk) begin
      if (cyc[g] && stb[g]) begin
        if (ack[g]) begin
          stall  <= 0;
          target <= int'($urandom_range(maxw[g]));
          if (we[g]) mem[idx] <= dato[g];
        end else begin
          stall <= stall + 1;
        end
      end else begin
        stall <= 0;
      end
    end

    wb_sdram_selftest #(
      .ADDR_LOW  (BASE),
      .WORDS     (WD),
      .BURST_LEN (BL),
      .SEED      (SEED),
      .TIMEOUT   (16)
    ) dut (
      .wb_clk    (clk),
      .wb_rst    (rst),
      .start     (start[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .pass      (pass[g]),
      .timeout   (tmo[g]),
      .err_count (errc[g]),
      .err_adr   (errad[g]),
      .wb_adr_o  (adr[g]),
      .wb_dat_o  (dato[g]),
      .wb_sel_o  (sel[g]),
      .wb_we_o   (we[g]),
      .wb_cyc_o  (cyc[g]),
      .wb_stb_o  (stb[g]),
      .wb_cti_o  (cti[g]),
      .wb_bte_o  (bte[g]),
      .wb_dat_i  (dati[g]),
      .wb_ack_i  (ack[g])
    );
  end

  // word-level model: beat k of a phase, gap after each burst
  int k [2] = '{0, 0};
  bit ph [2] = '{0, 0};
  bit gap [2] = '{0, 0};
  bit need [2] = '{0, 0};
  bit live [2] = '{0, 0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        live[i] = 0;
      end else if (start[i] && go[i]) begin
        live[i] = 1; k[i] = 0; ph[i] = 0;
        gap[i] = 0; need[i] = 1;
      end else if (live[i]) begin
        if (gap[i]) begin
          chk("gap_idle", 32'(cyc[i]), 0);
          gap[i] = 0;
          need[i] = 1;
        end else if (need[i]) begin
          chk("bus_up", 32'(cyc[i]), 1);
          need[i] = 0;
        end
        if (cyc[i]) begin
          automatic int b = bl_of(i);
          automatic bit lb = (k[i] % b) == b - 1;
          automatic logic [31:0] ec =
            (b == 1) ? 32'h0 : (lb ? 32'h7 : 32'h2);
          chk("adr", adr[i], base_of(i) + 32'(4 * k[i]));
          chk("we", 32'(we[i]), 32'(!ph[i]));
          chk("cti", 32'(cti[i]), ec);
          chk("stb", 32'(stb[i]), 1);
          chk("sel", 32'(sel[i]), 32'hF);
          chk("bte", 32'(bte[i]), 0);
          chk("busy_run", 32'(busy[i]), 1);
          if (!ph[i]) chk("dat", dato[i], pat[k[i]]);
          if (ack[i]) begin
            if (lb) gap[i] = 1;
            k[i]++;
            if (k[i] == words_of(i)) begin
              if (!ph[i]) begin
                ph[i] = 1; k[i] = 0;
              end else begin
                live[i] = 0;
              end
            end
          end
        end
      end
    end
  end

  task automatic kick(input int i);
    go[i] = 1'b1;
    start[i] = 1'b1;
    @(posedge clk); #1;
    start[i] = 1'b0;
    go[i] = 1'b0;
  endtask

  task automatic restart(input int i);
    start[i] = 1'b1;
    @(posedge clk); #1;
    start[i] = 1'b0;
    chk("restart_done_clr", 32'(done[i]), 0);
  endtask

  task automatic run(input int i, output int n);
    kick(i);
    n = 1;
    while (!done[i] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("run_done", 32'(done[i]), 1);
    @(posedge clk); #1;
  endtask

  int n, s, ecnt;
  logic [31:0] p, eadr;

  initial begin
    rst = 1'b1;
    start = '0; go = '0; fault = '0; noack = '0;
    maxw[0] = 0; maxw[1] = 0;

    p = SEED;
    for (int j = 0; j < 64; j++) begin
      pat[j] = p;
      p = (p >> 1) ^ (p[0] ? 32'h8020_0003 : 32'h0);
    end
    chk("pat1", pat[1], 32'h5670_9234);
    chk("pat3", pat[3], 32'h159C_248D);
    chk("pat4", pat[4], 32'h8AEE_1245);

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_cyc", 32'(cyc[i]), 0);
      chk("rst_busy", 32'(busy[i]), 0);
      chk("rst_done", 32'(done[i]), 0);
      chk("rst_pass", 32'(pass[i]), 0);
      chk("rst_tmo", 32'(tmo[i]), 0);
      chk("rst_errc", 32'(errc[i]), 0);
      chk("rst_erradr", errad[i], 0);
      chk("rst_adr", adr[i], 0);
      chk("rst_dat", dato[i], 0);
      chk("rst_cti", 32'(cti[i]), 0);
      chk("rst_we", 32'(we[i]), 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    run(0, n);
    chk("cycles_bl8", n, 146);
    chk("pass_bl8", 32'(pass[0]), 1);
    chk("errc_bl8", 32'(errc[0]), 0);
    chk("busy_done", 32'(busy[0]), 0);
    chk("cyc_done", 32'(cyc[0]), 0);

    run(1, n);
    chk("cycles_bl1", n, 66);
    chk("pass_bl1", 32'(pass[1]), 1);

    maxw[0] = 5; maxw[1] = 5;
    restart(0);
    run(0, n);
    chk("pass_wait_bl8", 32'(pass[0]), 1);
    chk("tmo_wait_bl8", 32'(tmo[0]), 0);
    restart(1);
    run(1, n);
    chk("pass_wait_bl1", 32'(pass[1]), 1);

    ecnt = 0; eadr = 0;
    for (int j = 16; j < 64; j++) begin
      if (pat[j][5]) begin
        if (ecnt == 0) eadr = 32'(4 * j);
        ecnt++;
      end
    end
    maxw[0] = 3;
    fault[0] = 1'b1;
    restart(0);
    run(0, n);
    fault[0] = 1'b0;
    chk("fault_errc", 32'(errc[0]), 32'(ecnt));
    chk("fault_erradr", errad[0], eadr);
    chk("fault_pass", 32'(pass[0]), 32'(ecnt == 0));
    chk("fault_tmo", 32'(tmo[0]), 0);

    noack[0] = 1'b1;
    restart(0);
    kick(0);
    n = 0; s = 0;
    while (!done[0] && n < 200) begin
      @(negedge clk);
      n++;
      if (stb[0]) s++;
    end
    noack[0] = 1'b0;
    chk("tmo_stb_cycles", s, 16);
    chk("tmo_flag", 32'(tmo[0]), 1);
    chk("tmo_done", 32'(done[0]), 1);
    chk("tmo_pass", 32'(pass[0]), 0);
    chk("tmo_cyc", 32'(cyc[0]), 0);
    chk("tmo_busy", 32'(busy[0]), 0);
    @(posedge clk); #1;

    maxw[0] = 2;
    restart(0);
    kick(0);
    n = 0;
    while (!(cyc[0] && adr[0] == 32'hC) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("beat4_reached", 32'(cyc[0] && adr[0] == 32'hC), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_cyc", 32'(cyc[0]), 0);
    chk("arst_stb", 32'(stb[0]), 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("arst_tmo", 32'(tmo[0]), 0);
    chk("arst_busy", 32'(busy[0]), 0);
    chk("arst_adr", adr[0], 0);
    @(posedge clk); #1;
    run(0, n);
    chk("rerun_pass", 32'(pass[0]), 1);
    chk("rerun_errc", 32'(errc[0]), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
